// File: rtl/dmem_responder_if.sv
// Data-memory bus between the core's load/store unit (master) and the
// memory responder (slave).
interface dmem_responder_if;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic        dre;
    logic [31:0] drdata;
    logic        dready;
    logic        derr;

    modport master (
        output daddr, dwdata, dwe, dre,
        input  drdata, dready, derr
    );

    modport slave (
        input  daddr, dwdata, dwe, dre,
        output drdata, dready, derr
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a small I/O page (output register,
// cycle and store counters), with programmable wait states before dready.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic [31:0]       io_out
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [3:0]    wait_cnt_r;
    logic [31:2]   addr_r;
    logic [31:0]   wdata_r;
    logic [3:0]    we_r;
    logic [31:0]   cyc_cnt_r;
    logic [31:0]   st_cnt_r;
    logic [31:0]   io_out_r;
    logic [31:0]   drdata_r;
    logic          dready_r;
    logic          derr_r;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          req_s;
    logic          enter_done_s;
    logic [31:2]   acc_addr_s;
    logic [31:0]   acc_wdata_s;
    logic [3:0]    acc_we_s;
    logic          acc_wr_s;
    logic [AW-1:0] idx_s;
    logic          is_ram_s;
    logic          sel_io_s;
    logic          sel_cyc_s;
    logic          sel_st_s;
    logic          unmapped_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // dre is part of the request but only matters through the write/read split.
    assign req_s    = bus.dre | (|bus.dwe);
    assign unused_s = ^bus.daddr[1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r <= 4'd1) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/access logic; with zero wait states the access happens on the
    // sampling edge itself, so the live bus is used while still in IDLE.
    always_comb begin
        enter_done_s = 1'b0;
        acc_addr_s   = addr_r;
        acc_wdata_s  = wdata_r;
        acc_we_s     = we_r;
        rdata_s      = 32'd0;
        if ((state_nxt_s == ST_DONE) && (state_r != ST_DONE) && !reset) begin
            enter_done_s = 1'b1;
        end else begin
            enter_done_s = 1'b0;
        end
        if (state_r == ST_IDLE) begin
            acc_addr_s  = bus.daddr[31:2];
            acc_wdata_s = bus.dwdata;
            acc_we_s    = bus.dwe;
        end else begin
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_we_s    = we_r;
        end
        acc_wr_s   = |acc_we_s;
        idx_s      = acc_addr_s[AW+1:2];
        is_ram_s   = (acc_addr_s[31:28] == 4'h0);
        sel_io_s   = (acc_addr_s[31:28] == 4'h8) && (acc_addr_s[27:2] == 26'd0);
        sel_cyc_s  = (acc_addr_s[31:28] == 4'h8) && (acc_addr_s[27:2] == 26'd1);
        sel_st_s   = (acc_addr_s[31:28] == 4'h8) && (acc_addr_s[27:2] == 26'd2);
        unmapped_s = !(is_ram_s || sel_io_s || sel_cyc_s || sel_st_s);
        // The cycle counter reports the value it takes at the DONE edge.
        if (is_ram_s) begin
            rdata_s = mem[idx_s];
        end else if (sel_io_s) begin
            rdata_s = io_out_r;
        end else if (sel_cyc_s) begin
            rdata_s = cyc_cnt_r + 32'd1;
        end else if (sel_st_s) begin
            rdata_s = st_cnt_r;
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Request latch and wait-state countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r     <= 30'd0;
            wdata_r    <= 32'd0;
            we_r       <= 4'd0;
            wait_cnt_r <= 4'd0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            addr_r     <= bus.daddr[31:2];
            wdata_r    <= bus.dwdata;
            we_r       <= bus.dwe;
            wait_cnt_r <= 4'(WAIT_CYCLES);
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Completion outputs, registered at the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            dready_r <= 1'b0;
            derr_r   <= 1'b0;
            drdata_r <= 32'd0;
        end else begin
            dready_r <= enter_done_s;
            derr_r   <= enter_done_s & unmapped_s;
            if (enter_done_s) begin
                drdata_r <= rdata_s;
            end
        end
    end

    // I/O register and counters; dropped writes still count as stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_r <= 32'd0;
            st_cnt_r  <= 32'd0;
            io_out_r  <= 32'd0;
        end else begin
            cyc_cnt_r <= cyc_cnt_r + 32'd1;
            if (enter_done_s && acc_wr_s) begin
                st_cnt_r <= st_cnt_r + 32'd1;
            end
            if (enter_done_s && acc_wr_s && sel_io_s) begin
                io_out_r <= lane_merge(io_out_r, acc_wdata_s, acc_we_s);
            end
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (enter_done_s && acc_wr_s && is_ram_s) begin
            mem[idx_s] <= lane_merge(mem[idx_s], acc_wdata_s, acc_we_s);
        end
    end

    assign bus.drdata = drdata_r;
    assign bus.dready = dready_r;
    assign bus.derr   = derr_r;
    assign io_out     = io_out_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: main instance with one wait state,
// plus zero- and three-wait-state instances for throughput checks.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if m_if ();
    dmem_responder_if b0 ();
    dmem_responder_if b3 ();
    logic [31:0] io_m, io_0, io_3;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .bus(m_if.slave), .io_out(io_m));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .bus(b0.slave), .io_out(io_0));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .bus(b3.slave), .io_out(io_3));

    typedef struct {
        logic [31:0] rdata;
        logic        derr;
        logic        chk_data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          dready_cnt = 0;
    logic [31:0] st_model = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every dready pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (m_if.dready === 1'b1) begin
            dready_cnt++;
            chk("unexpected_dready", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk_data) chk("drdata", m_if.drdata, e.rdata);
                chk("derr", {31'd0, m_if.derr}, {31'd0, e.derr});
            end
        end else if (m_if.derr === 1'b1) begin
            chk("derr_without_dready", {31'd0, m_if.dready}, 32'd1);
        end
    end

    // Drive one request at a negedge, wait (bounded) for dready, then release.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                          input logic re, input logic [31:0] er, input logic ed,
                          input logic cd, input string tag);
        exp_t e;
        int n;
        e.rdata = er; e.derr = ed; e.chk_data = cd;
        sb_q.push_back(e);
        if (we != 4'd0) st_model = st_model + 32'd1;
        m_if.daddr = a; m_if.dwdata = wd; m_if.dwe = we; m_if.dre = re;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_if.dready !== 1'b1 && n < 20);
        chk({tag, "_latency"}, n, 32'd2);
        m_if.dre = 1'b0; m_if.dwe = 4'd0;
        @(negedge clk);
    endtask

    initial begin
        int          last_t[2];
        logic [31:0] last_d[2];
        int          npulse[2];
        int          sp[2];
        logic        rdy[2];
        logic [31:0] dat[2];
        int          d0;

        m_if.daddr = 32'd0; m_if.dwdata = 32'd0; m_if.dwe = 4'd0; m_if.dre = 1'b0;
        b0.daddr = 32'd0; b0.dwdata = 32'd0; b0.dwe = 4'd0; b0.dre = 1'b0;
        b3.daddr = 32'd0; b3.dwdata = 32'd0; b3.dwe = 4'd0; b3.dre = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_dready", {31'd0, m_if.dready}, 32'd0);
        chk("rst_drdata", m_if.drdata, 32'd0);
        chk("rst_io_out", io_m, 32'd0);
        chk("rst_derr", {31'd0, m_if.derr}, 32'd0);

        // Counter is 5 after five idle edges; sampling edge makes 6, DONE edge 7.
        access(32'h8000_0004, 32'd0, 4'b0000, 1'b1, 32'd7, 1'b0, 1'b1, "cyc_rd");

        access(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'd0, 1'b0, 1'b0, "wr_full");
        access(32'h0000_0010, 32'h0000_5500, 4'b0010, 1'b0, 32'd0, 1'b0, 1'b0, "wr_lane1");
        access(32'h0000_0010, 32'd0, 4'b0000, 1'b1, 32'hDEAD_55EF, 1'b0, 1'b1, "rd_merge");

        access(32'h0000_1000, 32'h1234_5678, 4'b1111, 1'b0, 32'd0, 1'b0, 1'b0, "wr_alias");
        access(32'h0000_0000, 32'd0, 4'b0000, 1'b1, 32'h1234_5678, 1'b0, 1'b1, "rd_wrap");
        access(32'h4000_0000, 32'd0, 4'b0000, 1'b1, 32'd0, 1'b1, 1'b1, "rd_unmapped");

        access(32'h0000_0020, 32'hAAAA_AAAA, 4'b1111, 1'b0, 32'd0, 1'b0, 1'b0, "wr_a");
        access(32'h0000_0020, 32'h5555_5555, 4'b1111, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b1, "rbw");
        access(32'h0000_0020, 32'd0, 4'b0000, 1'b1, 32'h5555_5555, 1'b0, 1'b1, "rbw_after");
        access(32'h8000_0008, 32'd0, 4'b0000, 1'b1, st_model, 1'b0, 1'b1, "st_rd5");

        access(32'h8000_0008, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'd0, 1'b0, 1'b0, "wr_ro");
        access(32'h8000_0008, 32'd0, 4'b0000, 1'b1, st_model, 1'b0, 1'b1, "st_rd6");
        access(32'h4000_0000, 32'h0000_0001, 4'b1111, 1'b0, 32'd0, 1'b1, 1'b0, "wr_unmapped");
        access(32'h8000_000C, 32'h0000_0001, 4'b1111, 1'b0, 32'd0, 1'b1, 1'b0, "wr_io_hole");
        access(32'h8000_000C, 32'd0, 4'b0000, 1'b1, 32'd0, 1'b1, 1'b1, "rd_io_hole");

        access(32'h8000_0000, 32'h1122_3344, 4'b1111, 1'b0, 32'd0, 1'b0, 1'b1, "io_wr");
        chk("io_full", io_m, 32'h1122_3344);
        access(32'h8000_0000, 32'hAB00_0000, 4'b1000, 1'b0, 32'h1122_3344, 1'b0, 1'b1, "io_lane3");
        chk("io_lane3", io_m, 32'hAB22_3344);
        access(32'h8000_0000, 32'd0, 4'b0000, 1'b1, 32'hAB22_3344, 1'b0, 1'b1, "io_rd");
        access(32'h8000_0008, 32'd0, 4'b0000, 1'b1, st_model, 1'b0, 1'b1, "st_rd10");

        // Abort a write to io_out by resetting while the access is waiting.
        d0 = dready_cnt;
        m_if.daddr = 32'h8000_0000; m_if.dwdata = 32'hFFFF_FFFF; m_if.dwe = 4'b1111;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_if.dwe = 4'd0;
        st_model = 32'd0;
        repeat (4) @(negedge clk);
        chk("abort_no_dready", dready_cnt, d0);
        chk("abort_io_out", io_m, 32'd0);
        access(32'h8000_0008, 32'd0, 4'b0000, 1'b1, 32'd0, 1'b0, 1'b1, "abort_st_cleared");
        access(32'h8000_0000, 32'd0, 4'b0000, 1'b1, 32'd0, 1'b0, 1'b1, "abort_io_rd");

        // Back-to-back cycle-counter reads: spacing and counter delta are W+2.
        b0.daddr = 32'h8000_0004; b0.dre = 1'b1;
        b3.daddr = 32'h8000_0004; b3.dre = 1'b1;
        sp[0] = 2; sp[1] = 5;
        for (int k = 0; k < 2; k++) begin
            last_t[k] = -1; last_d[k] = 32'd0; npulse[k] = 0;
        end
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            rdy[0] = b0.dready; dat[0] = b0.drdata;
            rdy[1] = b3.dready; dat[1] = b3.drdata;
            for (int k = 0; k < 2; k++) begin
                if (rdy[k] === 1'b1) begin
                    if (last_t[k] >= 0) begin
                        chk(k == 0 ? "spacing_w0" : "spacing_w3", t - last_t[k], sp[k]);
                        chk(k == 0 ? "cyc_delta_w0" : "cyc_delta_w3", dat[k] - last_d[k], sp[k]);
                    end
                    last_t[k] = t; last_d[k] = dat[k]; npulse[k]++;
                end else if (last_t[k] >= 0) begin
                    chk(k == 0 ? "hold_w0" : "hold_w3", dat[k], last_d[k]);
                end
            end
        end
        chk("pulses_w0", 32'(npulse[0] >= 18), 32'd1);
        chk("pulses_w3", 32'(npulse[1] >= 7), 32'd1);
        b0.dre = 1'b0; b3.dre = 1'b0;

        repeat (8) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
